// File: rtl/sysop_issue.sv
// ---------------------------------------------------------------------------
// sysop_issue
//   Issue side of the CSR unit. Accepts one decoded RISC-V SYSTEM instruction
//   at a time, turns it into a single-cycle CSR command and returns the old
//   CSR value for rd writeback. For ECALL/MRET it waits for the CSR trap
//   response and forwards it as a fetch redirect, or raises err if the
//   response does not arrive within TRAP_TIMEOUT cycles. All outputs are
//   registered.
//
//   Optional feature (macro SYSOP_ILLEGAL_EN):
//     defined   - unsupported encodings and CSRRW/CSRRWI to the read-only
//                 space (0xC00-0xFFF) pulse illegal; no command is issued.
//     undefined - unsupported encodings retire as NOP, illegal stays 0.
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   in_valid/in_ready                  instruction handshake (ready only in IDLE)
//   in_inst, in_pc, in_rs1             instruction word, pc, rs1 value
//   csr_pc/cause/tval/wdata            CSR command, valid for one cycle (ISSUE)
//   csr_rdata, csr_r_valid             CSR readback
//   csr_trap_en, csr_trap_pc           trap/return response
//   rd_we, rd_addr, rd_data            writeback strobe and payload
//   redirect_en, redirect_pc           fetch redirect strobe and target
//   busy                               not IDLE
//   err                                trap response timeout strobe
//   illegal                            illegal encoding strobe
//
// States
//   S_IDLE      | waiting for an instruction
//   S_ISSUE     | CSR command on the bus for one cycle
//   S_WB        | rd writeback strobe
//   S_WAIT_TRAP | waiting for csr_trap_en after ECALL/MRET
// ---------------------------------------------------------------------------
module sysop_issue #(
  parameter int unsigned TRAP_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [63:0] in_pc,
  input  logic [63:0] in_rs1,
  output logic [63:0] csr_pc,
  output logic [4:0]  csr_cause,
  output logic [63:0] csr_tval,
  output logic [63:0] csr_wdata,
  input  logic [63:0] csr_rdata,
  input  logic        csr_r_valid,
  input  logic        csr_trap_en,
  input  logic [63:0] csr_trap_pc,
  output logic        rd_we,
  output logic [4:0]  rd_addr,
  output logic [63:0] rd_data,
  output logic        redirect_en,
  output logic [63:0] redirect_pc,
  output logic        busy,
  output logic        err,
  output logic        illegal
);

  // Command codes shared with the csr block.
  localparam logic [4:0] SYSOP_CSR_W = 5'd1;
  localparam logic [4:0] SYSOP_CSR_S = 5'd2;
  localparam logic [4:0] SYSOP_CSR_C = 5'd3;
  localparam logic [4:0] SYSOP_ECALL = 5'd4;
  localparam logic [4:0] SYSOP_RET   = 5'd5;

  localparam int unsigned CNT_W   = $clog2(TRAP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TRAP_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WB        = 2'd2,
    S_WAIT_TRAP = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  logic        in_ready_q, in_ready_d;
  logic        busy_q, busy_d;
  logic [63:0] csr_pc_q, csr_pc_d;
  logic [4:0]  csr_cause_q, csr_cause_d;
  logic [63:0] csr_tval_q, csr_tval_d;
  logic [63:0] csr_wdata_q, csr_wdata_d;
  logic        rd_we_q, rd_we_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [63:0] rd_data_q, rd_data_d;
  logic        redirect_en_q, redirect_en_d;
  logic [63:0] redirect_pc_q, redirect_pc_d;
  logic        err_q, err_d;
  logic        illegal_q, illegal_d;

  // Decode of the offered instruction
  logic [2:0]  funct3;
  logic [11:0] imm12;
  logic        is_system;
  logic [4:0]  dec_cause;
  logic [63:0] dec_tval;
  logic [63:0] dec_wdata;
  logic        dec_illegal;

  assign funct3    = in_inst[14:12];
  assign imm12     = in_inst[31:20];
  assign is_system = (in_inst[6:0] == 7'b1110011);

  always_comb begin
    dec_cause = 5'd0;
    dec_tval  = 64'd0;
    dec_wdata = 64'd0;
    if (is_system) begin
      case (funct3)
        3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111: begin
          case (funct3[1:0])
            2'b01:   dec_cause = SYSOP_CSR_W;
            2'b10:   dec_cause = SYSOP_CSR_S;
            default: dec_cause = SYSOP_CSR_C;
          endcase
          dec_tval  = {52'd0, imm12};
          // funct3[2] selects the immediate (zimm) forms
          dec_wdata = funct3[2] ? {59'd0, in_inst[19:15]} : in_rs1;
        end
        3'b000: begin
          if (imm12 == 12'h000)      dec_cause = SYSOP_ECALL;
          else if (imm12 == 12'h302) dec_cause = SYSOP_RET;
        end
        default: dec_cause = 5'd0;
      endcase
    end
  end

`ifdef SYSOP_ILLEGAL_EN
  logic dec_ro_write;
  // Read-only CSRs live at 0xC00-0xFFF (top two address bits set)
  assign dec_ro_write = (dec_cause == SYSOP_CSR_W) && (imm12[11:10] == 2'b11);
  assign dec_illegal  = (dec_cause == 5'd0) || dec_ro_write;
`else
  assign dec_illegal  = 1'b0;
`endif

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    rd_d          = rd_q;
    cnt_d         = cnt_q;
    csr_pc_d      = 64'd0;
    csr_cause_d   = 5'd0;
    csr_tval_d    = 64'd0;
    csr_wdata_d   = 64'd0;
    rd_we_d       = 1'b0;
    rd_addr_d     = 5'd0;
    rd_data_d     = 64'd0;
    redirect_en_d = 1'b0;
    redirect_pc_d = 64'd0;
    err_d         = 1'b0;
    illegal_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          rd_d = in_inst[11:7];
          if (dec_illegal) begin
            illegal_d = 1'b1;
          end else if (dec_cause != 5'd0) begin
            csr_pc_d    = in_pc;
            csr_cause_d = dec_cause;
            csr_tval_d  = dec_tval;
            csr_wdata_d = dec_wdata;
            state_d     = S_ISSUE;
          end
          // otherwise: unsupported encoding retires silently as a NOP
        end
      end
      S_ISSUE: begin
        if ((csr_cause_q == SYSOP_ECALL) || (csr_cause_q == SYSOP_RET)) begin
          cnt_d   = '0;
          state_d = S_WAIT_TRAP;
        end else begin
          rd_we_d   = (rd_q != 5'd0);
          rd_addr_d = rd_q;
          rd_data_d = csr_r_valid ? csr_rdata : 64'd0;
          state_d   = S_WB;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      S_WAIT_TRAP: begin
        cnt_d = cnt_inc;
        // A response in the final waiting cycle still beats the timeout
        if (csr_trap_en) begin
          redirect_en_d = 1'b1;
          redirect_pc_d = csr_trap_pc;
          state_d       = S_IDLE;
        end else if (cnt_inc == CNT_MAX) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rd_q          <= 5'd0;
      cnt_q         <= '0;
      in_ready_q    <= 1'b1;
      busy_q        <= 1'b0;
      csr_pc_q      <= 64'd0;
      csr_cause_q   <= 5'd0;
      csr_tval_q    <= 64'd0;
      csr_wdata_q   <= 64'd0;
      rd_we_q       <= 1'b0;
      rd_addr_q     <= 5'd0;
      rd_data_q     <= 64'd0;
      redirect_en_q <= 1'b0;
      redirect_pc_q <= 64'd0;
      err_q         <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_q          <= rd_d;
      cnt_q         <= cnt_d;
      in_ready_q    <= in_ready_d;
      busy_q        <= busy_d;
      csr_pc_q      <= csr_pc_d;
      csr_cause_q   <= csr_cause_d;
      csr_tval_q    <= csr_tval_d;
      csr_wdata_q   <= csr_wdata_d;
      rd_we_q       <= rd_we_d;
      rd_addr_q     <= rd_addr_d;
      rd_data_q     <= rd_data_d;
      redirect_en_q <= redirect_en_d;
      redirect_pc_q <= redirect_pc_d;
      err_q         <= err_d;
      illegal_q     <= illegal_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign csr_pc      = csr_pc_q;
  assign csr_cause   = csr_cause_q;
  assign csr_tval    = csr_tval_q;
  assign csr_wdata   = csr_wdata_q;
  assign rd_we       = rd_we_q;
  assign rd_addr     = rd_addr_q;
  assign rd_data     = rd_data_q;
  assign redirect_en = redirect_en_q;
  assign redirect_pc = redirect_pc_q;
  assign err         = err_q;
  assign illegal     = illegal_q;

endmodule
